gpio_modport: RTL and testbench
===============================

# gpio_modport

- Parameterised general-purpose I/O port block.
- A single-port register interface lets software do the following:
  - drive output pins;
  - set pin direction;
  - sample synchronised input pins;
  - take per-pin edge interrupts.
- It sits between the bus fabric and the chip pins. In verification, the GPIO agent drives `pin_i` and samples `pin_o`/`pin_oe` at `clk` posedge.

## Interface
- `WIDTH`, default 32: number of GPIO pins (1..1024). All data registers are `WIDTH` bits.
- `SYNC_STAGES`, default 2: flop stages on `pin_i` (2..4).
- `clk`  in  1  single clock; everything samples on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `pin_i`  in  WIDTH  pad input levels (asynchronous to `clk`).
- `pin_o`  out  WIDTH  pad output levels.
- `pin_oe`  out  WIDTH  pad output enable, 1 = drive.
- `wr_en`  in  1  register write strobe.
- `rd_en`  in  1  register read strobe.
- `addr`  in  3  register index.
- `wdata`  in  WIDTH  write data.
- `rdata`  out  WIDTH  read data, registered.
- `irq`  out  1  interrupt, OR of all `IRQ_STATUS` bits.

## Operation
- Register map (addr):
  - 0 `DATA_OUT` rw.
  - 1 `DIR` rw, 1 = output.
  - 2 `DATA_IN` ro, synchronised pins.
  - 3 `IRQ_EN` rw.
  - 4 `IRQ_TYPE` rw, 1 = rising edge, 0 = falling edge.
  - 5 `IRQ_STATUS` rw1c.
  - 6 `SET` wo: `DATA_OUT |= wdata`.
  - 7 `CLR` wo: `DATA_OUT &= ~wdata`.
- Write effects:
  - Writes to `DATA_IN` are ignored.
  - Reads of `SET` and `CLR` return 0.
- Pin outputs:
  - `pin_oe = DIR`.
  - `pin_o = DATA_OUT & DIR`: bits with direction input drive 0.
  - Both are combinational from the registers, with no extra flop.
- Input path:
  - `pin_i` passes through a `SYNC_STAGES` flop chain per bit.
  - The last stage is `DATA_IN`.
  - A history register holds the previous `DATA_IN`.
- Edge detect, per bit:
  - rise = `DATA_IN & ~hist`; fall = `~DATA_IN & hist`.
  - event = `IRQ_EN & (IRQ_TYPE ? rise : fall)`.
- Status update each cycle: `IRQ_STATUS <= (IRQ_STATUS & ~w1c_mask) | event`.
  - `w1c_mask` = `wdata` when `wr_en` and `addr==5`, else 0.
  - A new event in the same cycle as its W1C clear leaves the bit set (set wins).
- `irq` is the registered OR-reduce of the next `IRQ_STATUS`. It is asserted the cycle `IRQ_STATUS` becomes nonzero.
- Clearing `IRQ_EN` does not clear pending status.
- Reads: on `rd_en`, `rdata` loads the addressed register on the next edge. Otherwise `rdata` holds its value.
- A read and a write to the same address in one cycle return the pre-write value.

## Timing
- Reset (`rst` low, async): all of the following go to 0:
  - registers;
  - sync chain;
  - history;
  - `rdata`;
  - `irq`;
  - hence `pin_o` = 0 and `pin_oe` = 0.
- After `rst` rises, the first active edge performs normal operation.
- A `rst` assertion mid-operation takes effect immediately and overrides any in-flight write.
- Write latency: the register updates at the edge sampling `wr_en`. `pin_o`/`pin_oe` change in that same cycle, after the edge.
- Read latency: 1 cycle. `rdata` is valid the cycle after `rd_en`.
- Input latency: a `pin_i` change sampled at edge N appears in `DATA_IN` after edge N+`SYNC_STAGES`-1.
  - `IRQ_STATUS` and `irq` follow one edge later.
  - Default: readable 2 cycles after sampling; irq 3 edges after sampling.
- A pulse shorter than one clock may be missed; this is acceptable.
- No handshake: strobes are single-cycle qualifiers, and back-to-back accesses are allowed every cycle.

## Test plan
- Reset check: hold `rst` low with random `pin_i` → `pin_o`=0, `pin_oe`=0, `irq`=0, `rdata`=0.
- Set outputs:
  - Write `DIR`=0x0000_FFFF, then `DATA_OUT`=0xA5A5_A5A5 → `pin_oe`=0x0000_FFFF, `pin_o`=0x0000_A5A5.
  - Then `SET` 0x0000_0002 → `pin_o`=0x0000_A5A7.
  - Then `CLR` 0x0000_0005 → `pin_o`=0x0000_A5A2.
- Input sampling: drive `pin_i`=0x1234_5678 → reading addr 2 returns 0x1234_5678 no earlier than 2 cycles after the change is sampled.
- Rising-edge interrupt:
  - Set `IRQ_EN`=0x1 and `IRQ_TYPE`=0x1, then drive bit0 0→1 → `IRQ_STATUS`=0x1 and `irq`=1 after 3 edges.
  - A 1→0 transition does not set status.
  - W1C 0x1 → `irq`=0 on the next cycle.
- Clear/event collision: issue the W1C of bit0 in the exact cycle a new enabled rising edge is detected → `IRQ_STATUS` bit0 stays 1 and `irq` stays 1.
- Async reset mid-traffic: assert `rst` between clock edges while `DATA_OUT`=0xFFFF_FFFF and `DIR`=0xFFFF_FFFF → `pin_o` and `pin_oe` drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gpio_modport.sv
// Parameterised GPIO block: output drive, direction, synchronised input sampling
// and per-pin edge interrupts behind a single-port register interface.
module gpio_modport #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] pin_oe,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] ADDR_DIR        = 3'd1;
  localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN     = 3'd3;
  localparam logic [2:0] ADDR_IRQ_TYPE   = 3'd4;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
  localparam logic [2:0] ADDR_SET        = 3'd6;
  localparam logic [2:0] ADDR_CLR        = 3'd7;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_type;
  logic [WIDTH-1:0] irq_status;
  logic [WIDTH-1:0] hist;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irq_event;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] status_next;
  logic [WIDTH-1:0] rdata_next;

  assign data_in = sync_q[SYNC_STAGES-1];

  // Pads follow the registers directly so a write is visible right after its edge.
  assign pin_oe = dir;
  assign pin_o  = data_out & dir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rise      = data_in & ~hist;
  assign fall      = ~data_in & hist;
  assign irq_event = irq_en & ((irq_type & rise) | (~irq_type & fall));

  // The OR with irq_event comes last so a same-cycle event beats its W1C clear.
  assign w1c_mask    = (wr_en && addr == ADDR_IRQ_STATUS) ? wdata : '0;
  assign status_next = (irq_status & ~w1c_mask) | irq_event;

  always_comb begin
    data_out_next = data_out;
    if (wr_en) begin
      case (addr)
        ADDR_DATA_OUT: data_out_next = wdata;
        ADDR_SET:      data_out_next = data_out | wdata;
        ADDR_CLR:      data_out_next = data_out & ~wdata;
        default:       data_out_next = data_out;
      endcase
    end
  end

  always_comb begin
    rdata_next = '0;
    case (addr)
      ADDR_DATA_OUT:   rdata_next = data_out;
      ADDR_DIR:        rdata_next = dir;
      ADDR_DATA_IN:    rdata_next = data_in;
      ADDR_IRQ_EN:     rdata_next = irq_en;
      ADDR_IRQ_TYPE:   rdata_next = irq_type;
      ADDR_IRQ_STATUS: rdata_next = irq_status;
      default:         rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
      irq_type <= '0;
    end else begin
      data_out <= data_out_next;
      if (wr_en && addr == ADDR_DIR) begin
        dir <= wdata;
      end
      if (wr_en && addr == ADDR_IRQ_EN) begin
        irq_en <= wdata;
      end
      if (wr_en && addr == ADDR_IRQ_TYPE) begin
        irq_type <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist       <= '0;
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      hist       <= data_in;
      irq_status <= status_next;
      irq        <= |status_next;
    end
  end

  // The mux sees pre-write register values, so a same-cycle read returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rdata_next;
    end
  end

endmodule

// File: tb/tb_gpio_modport.sv
// Scoreboard bench for gpio_modport: reads push expected data into a queue that a
// separate monitor drains when rdata becomes valid; pad and irq levels are checked inline.
module tb_gpio_modport;

  logic        clk;
  logic        rst;
  logic [31:0] pin_i;
  logic [31:0] pin_o;
  logic [31:0] pin_oe;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic        rd_valid;

  gpio_modport #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (pin_i),
    .pin_o  (pin_o),
    .pin_oe (pin_oe),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // rdata is valid in the cycle after a read strobe is sampled.
  always @(posedge clk or negedge rst) begin
    if (!rst) rd_valid <= 1'b0;
    else      rd_valid <= rd_en;
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", rdata, 32'hxxxx_xxxx);
      end else begin
        check("read_data", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, input logic [31:0] req);
    @(negedge clk);
    rd_en = 1'b1;
    addr  = a;
    exp_q.push_back(req);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = 3'd0;
    wdata = 32'h0;
    pin_i = $urandom;

    // Reset with toggling pads.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pin_i = $urandom;
    end
    check("reset_pin_o", pin_o, 32'h0);
    check("reset_pin_oe", pin_oe, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    pin_i = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // Output drive, SET and CLR.
    write_reg(3'd1, 32'h0000_FFFF);
    write_reg(3'd0, 32'hA5A5_A5A5);
    check("pin_oe_dir", pin_oe, 32'h0000_FFFF);
    check("pin_o_masked", pin_o, 32'h0000_A5A5);
    write_reg(3'd6, 32'h0000_0002);
    check("pin_o_set", pin_o, 32'h0000_A5A7);
    write_reg(3'd7, 32'h0000_0005);
    check("pin_o_clr", pin_o, 32'h0000_A5A2);
    read_reg(3'd0, 32'hA5A5_A5A2);
    read_reg(3'd1, 32'h0000_FFFF);
    read_reg(3'd6, 32'h0);
    read_reg(3'd7, 32'h0);

    // Write to DATA_IN is ignored.
    write_reg(3'd2, 32'hFFFF_FFFF);
    read_reg(3'd2, 32'h0);

    // Input sampling latency with back-to-back reads.
    @(negedge clk);
    pin_i = 32'h1234_5678;
    rd_en = 1'b1;
    addr  = 3'd2;
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    rd_en = 1'b0;

    // Rising-edge interrupt on bit0.
    write_reg(3'd3, 32'h1);
    write_reg(3'd4, 32'h1);
    pin_i = 32'h1234_5679;
    @(negedge clk);
    check("irq_rise_edge1", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_rise_edge2", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_rise_edge3", {31'h0, irq}, 32'h1);
    read_reg(3'd5, 32'h1);

    // Same-cycle read and write returns pre-write value.
    @(negedge clk);
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = 3'd5;
    wdata = 32'h1;
    exp_q.push_back(32'h1);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("irq_w1c", {31'h0, irq}, 32'h0);

    // Falling edge with rising type sets nothing.
    pin_i = 32'h1234_5678;
    idle(4);
    check("irq_no_fall", {31'h0, irq}, 32'h0);
    read_reg(3'd5, 32'h0);

    // Collision: W1C lands in the cycle a new rising edge is detected.
    pin_i = 32'h1234_5679;
    idle(3);
    check("irq_pre_collision", {31'h0, irq}, 32'h1);
    pin_i = 32'h1234_5678;
    idle(3);
    pin_i = 32'h1234_5679;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = 3'd5;
    wdata = 32'h1;
    @(negedge clk);
    wr_en = 1'b0;
    check("irq_collision", {31'h0, irq}, 32'h1);
    read_reg(3'd5, 32'h1);

    // Falling-type interrupt on bit1; disabling IRQ_EN keeps pending status.
    write_reg(3'd3, 32'h3);
    write_reg(3'd4, 32'h1);
    pin_i = 32'h1234_567B;
    idle(4);
    read_reg(3'd5, 32'h1);
    pin_i = 32'h1234_5679;
    idle(4);
    read_reg(3'd5, 32'h3);
    write_reg(3'd3, 32'h0);
    read_reg(3'd5, 32'h3);
    check("irq_pending_after_disable", {31'h0, irq}, 32'h1);

    // Async reset between edges.
    write_reg(3'd1, 32'hFFFF_FFFF);
    write_reg(3'd0, 32'hFFFF_FFFF);
    check("pin_o_all", pin_o, 32'hFFFF_FFFF);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_pin_o", pin_o, 32'h0);
    check("async_pin_oe", pin_oe, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    check("async_rdata", rdata, 32'h0);
    idle(2);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
